memory_arbiter: RTL and testbench

- Sits directly downstream of the coherence controller in the dual-core memory subsystem, between it and the single-ported RAM.
- Arbitrates three word-wide requesters: the coherence controller's data port (D) and the two instruction caches (I0, I1).
- Drives the RAM request signals and returns per-requester wait/load.
- Provides the `d_wait` signal that the coherence controller uses to pace its two-word LOAD, WRITE_BACK and WRITE_MISS_CLEAN sequences.

---
 rtl/memory_arbiter.sv | 127 ++++++++++++
 tb/tb_memory_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Three-way RAM arbiter: coherence data port (D) and two icaches share one RAM port.
// The grant is combinational; a lock holds the owner across multi-cycle accesses.
module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_store,
  output logic              d_wait,
  output logic [ADDR_W-1:0] d_load,
  input  logic [1:0]        iren,
  input  logic [ADDR_W-1:0] iaddr0,
  input  logic [ADDR_W-1:0] iaddr1,
  output logic [1:0]        iwait,
  output logic [ADDR_W-1:0] iload0,
  output logic [ADDR_W-1:0] iload1,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate
);
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam logic [1:0] G_D    = 2'd0;
  localparam logic [1:0] G_I0   = 2'd1;
  localparam logic [1:0] G_I1   = 2'd2;
  localparam logic [1:0] G_NONE = 2'd3;

  logic             lock, rr;
  logic [1:0]       owner, grant, pick_i;
  logic [CNT_W-1:0] starve;
  logic             d_req, owner_req, access, i_done;

  assign d_req  = d_ren | d_wen;
  assign access = (ramstate == RS_ACCESS);
  assign i_done = access && (grant == G_I0 || grant == G_I1);

  always_comb begin
    owner_req = 1'b0;
    case (owner)
      G_D:     owner_req = d_req;
      G_I0:    owner_req = iren[0];
      G_I1:    owner_req = iren[1];
      default: owner_req = 1'b0;
    endcase

    pick_i = G_NONE;
    if (iren[rr])       pick_i = rr ? G_I1 : G_I0;
    else if (iren[~rr]) pick_i = rr ? G_I0 : G_I1;

    // A locked owner that drops its request gets nothing this cycle, not a re-arbitration.
    grant = G_NONE;
    if (lock)                                          grant = owner_req ? owner : G_NONE;
    else if (starve >= CNT_W'(STARVE_LIMIT) && |iren) grant = pick_i;
    else if (d_req)                                    grant = G_D;
    else if (|iren)                                    grant = pick_i;
  end

  always_comb begin
    d_wait   = 1'b1;
    iwait    = 2'b11;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    d_load   = '0;
    iload0   = '0;
    iload1   = '0;
    case (grant)
      G_D: begin
        ramaddr = d_addr;
        d_load  = ramload;
        d_wait  = ~access;
        if (d_wen) begin
          ramWEN   = 1'b1;
          ramstore = d_store;
        end else begin
          ramREN = 1'b1;
        end
      end
      G_I0: begin
        ramREN   = 1'b1;
        ramaddr  = iaddr0;
        iload0   = ramload;
        iwait[0] = ~access;
      end
      G_I1: begin
        ramREN   = 1'b1;
        ramaddr  = iaddr1;
        iload1   = ramload;
        iwait[1] = ~access;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lock   <= 1'b0;
      owner  <= G_D;
      rr     <= 1'b0;
      starve <= '0;
    end else begin
      if (grant != G_NONE && !access && ramstate != RS_ERROR) begin
        lock  <= 1'b1;
        owner <= grant;
      end else begin
        lock  <= 1'b0;
      end

      if (i_done) begin
        rr     <= ~rr;
        starve <= '0;
      end else if (|iren && starve != '1) begin
        starve <= starve + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: inputs change after the falling edge and
// outputs are checked 1ns later, so every check sits mid low-phase.
module tb_memory_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        d_ren, d_wen;
  logic [31:0] d_addr, d_store, d_load;
  logic        d_wait;
  logic [1:0]  iren, iwait;
  logic [31:0] iaddr0, iaddr1, iload0, iload1;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  memory_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
    .d_wait(d_wait), .d_load(d_load),
    .iren(iren), .iaddr0(iaddr0), .iaddr1(iaddr1),
    .iwait(iwait), .iload0(iload0), .iload1(iload1),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    d_ren = 0; d_wen = 0; d_addr = 32'h100; d_store = 0;
    iren = 2'b00; iaddr0 = 32'hA000; iaddr1 = 32'hB000;
    ramload = 32'h1234_5678; ramstate = FREE;
  endtask

  task automatic pulse_reset();
    nRST = 1'b0; #1; nRST = 1'b1;
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    idle_inputs();
    step();

    // Reset held with requests present: outputs still follow the reset state.
    d_ren = 1; iren = 2'b11; ramstate = BUSY; #1;
    chk("rst_ramREN", ramREN, 1);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 32'h100);
    chk("rst_d_wait", d_wait, 1);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_lock", dut.lock, 0);
    step();
    nRST = 1'b1;
    step();
    chk("rst_lock_after", dut.lock, 1);
    chk("rst_owner_after", dut.owner, 0);

    // Idle outputs
    idle_inputs(); pulse_reset(); #1;
    chk("idle_d_wait", d_wait, 1);
    chk("idle_iwait", iwait, 2'b11);
    chk("idle_ramREN", ramREN, 0);
    chk("idle_ramaddr", ramaddr, 0);
    chk("idle_iload0", iload0, 0);
    chk("idle_d_load", d_load, 0);

    // D write, BUSY x2 then ACCESS; I0 arrives during the write and waits
    step();
    d_wen = 1; d_addr = 32'h40; d_store = 32'hDEADBEEF; ramstate = BUSY; #1;
    chk("wr1_ramWEN", ramWEN, 1);
    chk("wr1_ramREN", ramREN, 0);
    chk("wr1_ramstore", ramstore, 32'hDEADBEEF);
    chk("wr1_d_wait", d_wait, 1);
    step();
    iren = 2'b01; #1;
    chk("wr2_ramWEN", ramWEN, 1);
    chk("wr2_ramaddr", ramaddr, 32'h40);
    chk("wr2_iwait", iwait, 2'b11);
    step();
    ramstate = ACCESS; #1;
    chk("wr3_ramWEN", ramWEN, 1);
    chk("wr3_d_wait", d_wait, 0);
    chk("wr3_iwait", iwait, 2'b11);
    step();
    d_wen = 0; ramload = 32'hCAFE_0000; #1;
    chk("wr4_ramREN", ramREN, 1);
    chk("wr4_ramWEN", ramWEN, 0);
    chk("wr4_ramaddr", ramaddr, 32'hA000);
    chk("wr4_iwait", iwait, 2'b10);
    chk("wr4_iload0", iload0, 32'hCAFE_0000);
    chk("wr4_d_wait", d_wait, 1);

    // Read and write together: write wins, load still returned
    step();
    idle_inputs(); pulse_reset();
    d_ren = 1; d_wen = 1; d_addr = 32'h44; d_store = 32'h5555; ramstate = ACCESS; #1;
    chk("rw_ramWEN", ramWEN, 1);
    chk("rw_ramREN", ramREN, 0);
    chk("rw_d_load", d_load, 32'h1234_5678);
    chk("rw_d_wait", d_wait, 0);

    // Both icaches, ACCESS every cycle: strict alternation starting at I0
    step();
    idle_inputs(); pulse_reset();
    iren = 2'b11; ramstate = ACCESS;
    for (int i = 0; i < 4; i++) begin
      ramload = 32'h9000 + i; #1;
      chk("rr_iwait", iwait, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_ramaddr", ramaddr, (i % 2 == 0) ? 32'hA000 : 32'hB000);
      chk("rr_iload", (i % 2 == 0) ? iload0 : iload1, 32'h9000 + i);
      chk("rr_iload_other", (i % 2 == 0) ? iload1 : iload0, 0);
      step();
    end

    // Starvation: D served 8 times, then I1 forced once, then D again
    idle_inputs(); pulse_reset();
    d_ren = 1; d_addr = 32'h300; iren = 2'b10; ramstate = ACCESS;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stv_d_wait", d_wait, 0);
      chk("stv_iwait", iwait, 2'b11);
      step();
    end
    #1;
    chk("stv9_d_wait", d_wait, 1);
    chk("stv9_iwait", iwait, 2'b01);
    chk("stv9_ramaddr", ramaddr, 32'hB000);
    chk("stv9_iload1", iload1, 32'h1234_5678);
    step(); #1;
    chk("stv10_d_wait", d_wait, 0);
    chk("stv10_ramaddr", ramaddr, 32'h300);

    // ERROR during a D read: no completion, lock released, D regranted
    step();
    idle_inputs(); pulse_reset();
    d_ren = 1; d_addr = 32'h200; iren = 2'b01; ramstate = ERROR; #1;
    chk("err_d_wait", d_wait, 1);
    chk("err_iwait", iwait, 2'b11);
    chk("err_ramREN", ramREN, 1);
    step();
    chk("err_lock", dut.lock, 0);
    ramstate = ACCESS; #1;
    chk("err_retry_ramaddr", ramaddr, 32'h200);
    chk("err_retry_d_wait", d_wait, 0);

    // I0 locked, then drops: enables off, no completion, D next cycle
    step();
    idle_inputs(); pulse_reset();
    iren = 2'b01; ramstate = BUSY; #1;
    chk("drop1_ramaddr", ramaddr, 32'hA000);
    chk("drop1_ramREN", ramREN, 1);
    step();
    iren = 2'b00; d_ren = 1; d_addr = 32'h500; ramstate = ACCESS; #1;
    chk("drop2_ramREN", ramREN, 0);
    chk("drop2_iwait", iwait, 2'b11);
    chk("drop2_d_wait", d_wait, 1);
    step();
    chk("drop3_lock", dut.lock, 0);
    #1;
    chk("drop3_ramaddr", ramaddr, 32'h500);
    chk("drop3_d_wait", d_wait, 0);
    chk("drop3_d_load", d_load, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
